// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: op enum, opcode fields, immediate limits, error codes.
// Used by the encoder and by the decoder/controller and its bench.
// No logic lives here; types and constants only.
package legv8_pkg;

    // Symbolic op accepted by the encoder; codes 17..31 are illegal.
    typedef enum logic [4:0] {
        OP_B    = 5'd0,
        OP_BL   = 5'd1,
        OP_CBZ  = 5'd2,
        OP_CBNZ = 5'd3,
        OP_LDUR = 5'd4,
        OP_STUR = 5'd5,
        OP_ADD  = 5'd6,
        OP_AND  = 5'd7,
        OP_ORR  = 5'd8,
        OP_EOR  = 5'd9,
        OP_SUB  = 5'd10,
        OP_ADDI = 5'd11,
        OP_ANDI = 5'd12,
        OP_ORRI = 5'd13,
        OP_EORI = 5'd14,
        OP_SUBI = 5'd15,
        OP_MOVZ = 5'd16
    } op_e;

    // B-format opcodes (6 bits)
    localparam logic [5:0]  OPC_B     = 6'b000101;
    localparam logic [5:0]  OPC_BL    = 6'b100101;
    // CB-format opcodes (8 bits)
    localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ  = 8'b10110101;
    // D-format opcodes (11 bits)
    localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
    localparam logic [10:0] OPC_STUR  = 11'b11111000000;
    // R-format opcodes (11 bits)
    localparam logic [10:0] OPC_ADD   = 11'b10001011000;
    localparam logic [10:0] OPC_AND   = 11'b10001010000;
    localparam logic [10:0] OPC_ORR   = 11'b10101010000;
    localparam logic [10:0] OPC_EOR   = 11'b11101010000;
    localparam logic [10:0] OPC_SUB   = 11'b11001011000;
    // I-format opcodes (10 bits)
    localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OPC_ANDI  = 10'b1001001000;
    localparam logic [9:0]  OPC_ORRI  = 10'b1011001000;
    localparam logic [9:0]  OPC_EORI  = 10'b1101001000;
    localparam logic [9:0]  OPC_SUBI  = 10'b1101000100;
    // IM-format opcode (9 bits)
    localparam logic [8:0]  OPC_MOVZ  = 9'b110100101;

    // Immediate limits, inclusive, interpreted as 32-bit signed values.
    localparam int IMM_BR_MIN   = -(1 << 25);
    localparam int IMM_BR_MAX   = (1 << 25) - 1;
    localparam int IMM_CB_MIN   = -(1 << 18);
    localparam int IMM_CB_MAX   = (1 << 18) - 1;
    localparam int IMM_D_MIN    = -256;
    localparam int IMM_D_MAX    = 255;
    localparam int IMM_I_MIN    = 0;
    localparam int IMM_I_MAX    = 4095;
    localparam int IMM_MOVZ_MIN = 0;
    localparam int IMM_MOVZ_MAX = 65535;

    // Rejection reasons
    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_BAD_OP    = 2'd1;
    localparam logic [1:0] ERR_IMM_RANGE = 2'd2;

endpackage

// File: rtl/legv8_sync_fifo.sv
// Generic synchronous FIFO with registered slots; head shown directly from storage.
// Latency: word pushed at edge N is at the head after edge N if the FIFO was empty.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/empty.
module legv8_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [W-1:0]     push_dat_i,
    input  logic             pop_i,
    output logic [W-1:0]     pop_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Storage, pointers (wrapping modulo DEPTH) and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/legv8_instr_encoder.sv
// Packs a symbolic LEGv8 instruction into its 32-bit word, range-checks the immediate, queues it.
// Latency: accepted word reaches out_instr one edge later when the queue is empty.
// Backpressure: in_ready low while full (no bypass); rejected requests still consume the handshake.
module legv8_instr_encoder
    import legv8_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rn,
    input  logic [4:0]       in_rm,
    input  logic [31:0]      in_imm,
    input  logic [1:0]       in_hw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] count
);

    logic        full;
    logic        empty;
    logic        accept;
    logic        pop;
    logic        reject;
    logic [1:0]  rej_code;
    logic [31:0] word;
    logic        err_q;
    logic        err_d;
    logic [1:0]  err_code_q;
    logic [1:0]  err_code_d;
    int          imm_s;

    assign imm_s     = int'($signed(in_imm));
    assign in_ready  = !full;
    assign accept    = in_valid && in_ready;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    // Encode the request and decide whether it must be rejected.
    always_comb begin
        word     = '0;
        rej_code = ERR_NONE;
        case (in_op)
            OP_B, OP_BL: begin
                word = {(in_op == OP_B) ? OPC_B : OPC_BL, in_imm[25:0]};
                if (imm_s < IMM_BR_MIN || imm_s > IMM_BR_MAX) rej_code = ERR_IMM_RANGE;
            end
            OP_CBZ, OP_CBNZ: begin
                word = {(in_op == OP_CBZ) ? OPC_CBZ : OPC_CBNZ, in_imm[18:0], in_rd};
                if (imm_s < IMM_CB_MIN || imm_s > IMM_CB_MAX) rej_code = ERR_IMM_RANGE;
            end
            OP_LDUR, OP_STUR: begin
                word = {(in_op == OP_LDUR) ? OPC_LDUR : OPC_STUR, in_imm[8:0], 2'b00, in_rn, in_rd};
                if (imm_s < IMM_D_MIN || imm_s > IMM_D_MAX) rej_code = ERR_IMM_RANGE;
            end
            OP_ADD: word = {OPC_ADD, in_rm, 6'b000000, in_rn, in_rd};
            OP_AND: word = {OPC_AND, in_rm, 6'b000000, in_rn, in_rd};
            OP_ORR: word = {OPC_ORR, in_rm, 6'b000000, in_rn, in_rd};
            OP_EOR: word = {OPC_EOR, in_rm, 6'b000000, in_rn, in_rd};
            OP_SUB: word = {OPC_SUB, in_rm, 6'b000000, in_rn, in_rd};
            OP_ADDI, OP_ANDI, OP_ORRI, OP_EORI, OP_SUBI: begin
                case (in_op)
                    OP_ADDI: word = {OPC_ADDI, in_imm[11:0], in_rn, in_rd};
                    OP_ANDI: word = {OPC_ANDI, in_imm[11:0], in_rn, in_rd};
                    OP_ORRI: word = {OPC_ORRI, in_imm[11:0], in_rn, in_rd};
                    OP_EORI: word = {OPC_EORI, in_imm[11:0], in_rn, in_rd};
                    default: word = {OPC_SUBI, in_imm[11:0], in_rn, in_rd};
                endcase
                if (imm_s < IMM_I_MIN || imm_s > IMM_I_MAX) rej_code = ERR_IMM_RANGE;
            end
            OP_MOVZ: begin
                word = {OPC_MOVZ, in_hw, in_imm[15:0], in_rd};
                if (imm_s < IMM_MOVZ_MIN || imm_s > IMM_MOVZ_MAX) rej_code = ERR_IMM_RANGE;
            end
            default: rej_code = ERR_BAD_OP;
        endcase
    end

    assign reject     = (rej_code != ERR_NONE);
    assign err_d      = accept && reject;
    assign err_code_d = err_d ? rej_code : err_code_q;

    // One-cycle error pulse and sticky reason of the most recent rejection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign err      = err_q;
    assign err_code = err_code_q;

    legv8_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (32),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (accept && !reject),
        .push_dat_i (word),
        .pop_i      (pop),
        .pop_dat_o  (out_instr),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count)
    );

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Directed bench for legv8_instr_encoder with hand-encoded expected words.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure exercised by filling the queue with out_ready held low.
module tb_legv8_instr_encoder;
    import legv8_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rn;
    logic [4:0]  in_rm;
    logic [31:0] in_imm;
    logic [1:0]  in_hw;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        err;
    logic [1:0]  err_code;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    legv8_instr_encoder #(.DEPTH(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rn     (in_rn),
        .in_rm     (in_rm),
        .in_imm    (in_imm),
        .in_hw     (in_hw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .err       (err),
        .err_code  (err_code),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one edge.
    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [31:0] imm, input logic [1:0] hw);
        in_op    = op;
        in_rd    = rd;
        in_rn    = rn;
        in_rm    = rm;
        in_imm   = imm;
        in_hw    = hw;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Check the head, then pop it.
    task automatic pop_check(input string tag, input logic [31:0] exp);
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk(tag, out_instr, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_op     = '0;
        in_rd     = '0;
        in_rn     = '0;
        in_rm     = '0;
        in_imm    = '0;
        in_hw     = '0;

        // Reset state
        #12;
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_code", {30'd0, err_code}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD with consumer ready: visible one edge after accept, then drained
        out_ready = 1'b1;
        send(OP_ADD, 5'd11, 5'd9, 5'd24, 32'd0, 2'd0);
        chk("add_vld", {31'd0, out_valid}, 32'd1);
        chk("add_word", out_instr, 32'h8B18012B);
        chk("add_count1", {29'd0, count}, 32'd1);
        step();
        chk("add_count0", {29'd0, count}, 32'd0);
        out_ready = 1'b0;

        // Back-to-back ADDI, CBZ, B
        send(OP_ADDI, 5'd22, 5'd22, 5'd0, 32'd1, 2'd0);
        send(OP_CBZ, 5'd1, 5'd0, 5'd0, 32'h41, 2'd0);
        send(OP_B, 5'd0, 5'd0, 5'd0, 32'h41, 2'd0);
        chk("b2b_count", {29'd0, count}, 32'd3);
        pop_check("b2b_addi", 32'h910006D6);
        pop_check("b2b_cbz", 32'hB4000821);
        pop_check("b2b_b", 32'h14000041);

        // Loads, stores, MOVZ
        send(OP_LDUR, 5'd9, 5'd10, 5'd0, 32'd0, 2'd0);
        send(OP_STUR, 5'd9, 5'd10, 5'd0, 32'd0, 2'd0);
        send(OP_MOVZ, 5'd1, 5'd0, 5'd0, 32'd1, 2'd0);
        pop_check("ldur", 32'hF8400149);
        pop_check("stur", 32'hF8000149);
        pop_check("movz", 32'hD2800021);

        // Boundary immediates that must be accepted
        send(OP_LDUR, 5'd0, 5'd0, 5'd0, 32'hFFFF_FF00, 2'd0);
        chk("ldur_m256_err", {31'd0, err}, 32'd0);
        send(OP_ANDI, 5'd0, 5'd0, 5'd0, 32'd4095, 2'd0);
        pop_check("ldur_m256", 32'hF8500000);
        pop_check("andi_4095", 32'h923FFC00);

        // Fill: five offered, four accepted
        for (int i = 1; i <= 4; i++) begin
            send(OP_ADD, 5'(i), 5'd0, 5'd0, 32'd0, 2'd0);
        end
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        in_op     = OP_ADD;
        in_rd     = 5'd5;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        chk("full_nobypass_count", {29'd0, count}, 32'd3);
        chk("full_in_ready_back", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("full_refill_count", {29'd0, count}, 32'd4);
        pop_check("full_w2", 32'h8B000002);
        pop_check("full_w3", 32'h8B000003);
        pop_check("full_w4", 32'h8B000004);
        pop_check("full_w5", 32'h8B000005);
        chk("full_drained", {29'd0, count}, 32'd0);

        // Rejections
        send(OP_LDUR, 5'd0, 5'd0, 5'd0, 32'd256, 2'd0);
        chk("ldur256_err", {31'd0, err}, 32'd1);
        chk("ldur256_code", {30'd0, err_code}, 32'd2);
        chk("ldur256_count", {29'd0, count}, 32'd0);
        step();
        chk("ldur256_err_pulse", {31'd0, err}, 32'd0);
        chk("ldur256_code_hold", {30'd0, err_code}, 32'd2);
        send(5'd31, 5'd0, 5'd0, 5'd0, 32'd0, 2'd0);
        chk("badop_err", {31'd0, err}, 32'd1);
        chk("badop_code", {30'd0, err_code}, 32'd1);
        send(OP_SUBI, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 2'd0);
        chk("subi_m1_code", {30'd0, err_code}, 32'd2);
        send(OP_B, 5'd0, 5'd0, 5'd0, 32'h0200_0000, 2'd0);
        chk("b_over_err", {31'd0, err}, 32'd1);
        chk("rej_count", {29'd0, count}, 32'd0);

        // Asynchronous reset mid-stream
        send(OP_ADD, 5'd1, 5'd0, 5'd0, 32'd0, 2'd0);
        send(OP_ADD, 5'd2, 5'd0, 5'd0, 32'd0, 2'd0);
        send(OP_ADD, 5'd3, 5'd0, 5'd0, 32'd0, 2'd0);
        chk("pre_arst_count", {29'd0, count}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_count", {29'd0, count}, 32'd0);
        chk("arst_err_code", {30'd0, err_code}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_out_valid_after", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/legv8_instr_encoder.md
Name: legv8_instr_encoder

Overview:
- Producer-side counterpart to the LEGv8 decoder/controller: packs a symbolic instruction (op, register fields, immediate) into the 32-bit machine word the decoder consumes.
- Range-checks every field and buffers encoded words in a small FIFO with valid/ready on both sides.
- Feeds instruction memory preload logic and the decoder bench stimulus path.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 3, occupancy counter width; equals log2(DEPTH)+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request carries an instruction.
- in_ready  out  1  encoder accepts a request this cycle.
- in_op  in  5  op code (see package enum).
- in_rd  in  5  Rd / Rt field.
- in_rn  in  5  Rn field.
- in_rm  in  5  Rm field.
- in_imm  in  32  immediate, two's complement.
- in_hw  in  2  MOVZ shift selector.
- out_valid  out  1  FIFO head holds a word.
- out_ready  in  1  consumer takes the head this cycle.
- out_instr  out  32  encoded word at the FIFO head.
- err  out  1  one-cycle pulse: the accepted request was rejected.
- err_code  out  2  reason for the last rejection: 1 = bad op, 2 = immediate out of range; holds until the next rejection.
- count  out  CNT_W  FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0): FIFO empty, count=0, out_valid=0, out_instr=0, err=0, err_code=0, in_ready=1 once rst_n releases. Reset mid-stream discards all entries.
- Accept condition: in_valid && in_ready. in_ready = (count != DEPTH). There is no same-cycle bypass when full; in_ready stays 0 even if out_ready=1.
- Pop condition: out_valid && out_ready, with out_valid = (count != 0) and out_instr = head entry (a registered FIFO slot).
- Latency: a word accepted at edge N is visible on out_valid/out_instr after edge N when the FIFO was empty; otherwise in order behind older entries.
- Simultaneous push and pop: head advances, new word is written, count is unchanged.
- Encoding (combinational on the accepted request, written to the FIFO tail):
  - B: 000101 | imm26.
  - BL: 100101 | imm26.
  - CBZ: 10110100 | imm19 | Rt.
  - CBNZ: 10110101 | imm19 | Rt.
  - LDUR: 11111000010 | imm9 | 00 | Rn | Rt.
  - STUR: 11111000000 | imm9 | 00 | Rn | Rt.
  - R-type (ADD 10001011000, AND 10001010000, ORR 10101010000, EOR 11101010000, SUB 11001011000): opcode | Rm | shamt=000000 | Rn | Rd.
  - I-type (ADDI 1001000100, ANDI 1001001000, ORRI 1011001000, EORI 1101001000, SUBI 1101000100): opcode | imm12 | Rn | Rd.
  - MOVZ: 110100101 | hw | imm16 | Rd.
  - Fields are truncated to their low bits after the range check passes.
- Immediate range checks:
  - Signed: B/BL imm in [-2^25, 2^25-1]; CBZ/CBNZ in [-2^18, 2^18-1]; LDUR/STUR in [-256, 255].
  - Unsigned: I-type imm in [0, 4095]; MOVZ imm in [0, 65535].
  - Register fields and hw need no check.
- Rejection: an accepted request with an op outside the enum, or with an immediate out of range, is not enqueued. err pulses 1 for the cycle after acceptance and err_code updates. The request still consumes its handshake, so the producer must not retry the same beat.
- Back-to-back: one accept per cycle sustained while not full; one pop per cycle sustained while not empty.
- Pointers: read and write pointers wrap modulo DEPTH. count saturates by construction: no push when full, no pop when empty.

Decomposition:
- Package legv8_pkg holds:
  - the op enum: B, BL, CBZ, CBNZ, LDUR, STUR, ADD, AND, ORR, EOR, SUB, ADDI, ANDI, ORRI, EORI, SUBI, MOVZ (values 0-16).
  - opcode field constants for each format.
  - immediate-limit constants.
  - err_code localparams.
- The decoder and its bench share this package.
- One sub-module: legv8_sync_fifo (DEPTH, width 32, push/pop/full/empty/count).
- Encoding and range check stay inline in a single combinational block.

Test Plan:
- ADD rd=11 rn=9 rm=24, out_ready=1 -> out_instr=0x8B18012B one cycle after accept; count returns to 0.
- ADDI rd=22 rn=22 imm=1, then CBZ rt=1 imm=0x41, then B imm=0x41 back-to-back -> in order 0x910006D6, 0xB4000821, 0x14000041.
- LDUR rt=9 rn=10 imm=0 then STUR same fields -> 0xF8400149, 0xF8000149. MOVZ rd=1 imm=1 hw=0 -> 0xD2800021.
- out_ready=0, push 5 valid requests -> 4 accepted, count=4, in_ready=0. Then assert out_ready and in_valid together -> in_ready stays 0 until the first pop completes; output order preserved.
- LDUR imm=256 -> err=1 for one cycle, err_code=2, nothing enqueued. in_op=31 -> err_code=1. SUBI imm=-1 -> err_code=2.
- Push 3 words, pull rst_n low asynchronously mid-cycle -> out_valid=0, count=0 immediately; after release, in_ready=1.
